// File: rtl/rtc_pkg.sv
// rtc_pkg: shared types, constants and cycle helpers for the
// front-panel time-setting controller.
package rtc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SET_HH,
    SET_MM,
    SET_SS,
    COMMIT
  } rtc_state_t;

  typedef logic [1:0] fsel_t;

  localparam fsel_t FS_NONE = 2'd0;
  localparam fsel_t FS_HH   = 2'd1;
  localparam fsel_t FS_MM   = 2'd2;
  localparam fsel_t FS_SS   = 2'd3;

  localparam logic [7:0] HOURS_MOD  = 8'd24;
  localparam logic [7:0] MINSEC_MOD = 8'd60;

  function automatic int unsigned ms2cyc(
    input int unsigned f,
    input int unsigned ms
  );
    return f / 1000 * ms;
  endfunction

  function automatic int unsigned s2cyc(
    input int unsigned f,
    input int unsigned s
  );
    return f * s;
  endfunction

  // out-of-range values snap to 0 on inc, to mod-1 on dec
  function automatic logic [7:0] wrap_step(
    input logic [7:0] v,
    input logic [7:0] m,
    input logic       up
  );
    if (up)
      return (v >= m - 8'd1) ? 8'd0 : v + 8'd1;
    return (v == 8'd0 || v >= m) ? m - 8'd1 : v - 8'd1;
  endfunction

endpackage

// File: rtl/rtc_time_set_if.sv
// rtc_time_set_if: buttons, current-time feedback and load bus
// between the front panel, this controller and the clock.
interface rtc_time_set_if;
  import rtc_pkg::*;

  logic        btn_mode;
  logic        btn_inc;
  logic        btn_dec;
  logic [7:0]  cur_hours;
  logic [7:0]  cur_minutes;
  logic [7:0]  cur_seconds;
  logic [31:0] hhmmss;
  logic        wr;
  logic        editing;
  fsel_t       field_sel;

  modport master (
    output btn_mode, btn_inc, btn_dec,
    output cur_hours, cur_minutes, cur_seconds,
    input  hhmmss, wr, editing, field_sel
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec,
    input  cur_hours, cur_minutes, cur_seconds,
    output hhmmss, wr, editing, field_sel
  );

endinterface

// File: rtl/rtc_time_set_debounce.sv
// button_debounce: 2-flop sync, stable-level debounce and press pulse.
// Auto-repeat is built only with RTC_SET_AUTOREPEAT_EN.
module button_debounce
  import rtc_pkg::*;
#(
  parameter int unsigned DEB_CYC = 2
`ifdef RTC_SET_AUTOREPEAT_EN
  , parameter bit          REPEAT   = 1'b0
  , parameter int unsigned REP_DLY  = 5
  , parameter int unsigned REP_RATE = 2
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned DW = $clog2(DEB_CYC + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic          r_stable_d;
  logic          r_pulse;
  logic [DW-1:0] r_cnt;
  logic          w_rep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_pulse    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_s1       <= i_btn;
      r_s2       <= r_s1;
      r_stable_d <= r_stable;
      r_pulse    <= r_stable & ~r_stable_d;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == DW'(DEB_CYC - 1)) begin
        r_cnt    <= '0;
        r_stable <= r_s2;
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
    end
  end

`ifdef RTC_SET_AUTOREPEAT_EN
  if (REPEAT) begin : g_rep
    localparam int unsigned RMAX =
      (REP_DLY > REP_RATE) ? REP_DLY : REP_RATE;
    localparam int unsigned RW = $clog2(RMAX + 1);

    logic [RW-1:0] r_rcnt;
    logic          r_armed;
    logic          r_rpulse;

    // first repeat after REP_DLY, then every REP_RATE
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rcnt   <= '0;
        r_armed  <= 1'b0;
        r_rpulse <= 1'b0;
      end else if (!r_stable) begin
        r_rcnt   <= '0;
        r_armed  <= 1'b0;
        r_rpulse <= 1'b0;
      end else if (r_rcnt == RW'(r_armed ? REP_RATE - 1
                                          : REP_DLY - 1)) begin
        r_rcnt   <= '0;
        r_armed  <= 1'b1;
        r_rpulse <= 1'b1;
      end else begin
        r_rcnt   <= r_rcnt + RW'(1);
        r_rpulse <= 1'b0;
      end
    end

    assign w_rep = r_rpulse;
  end else begin : g_norep
    assign w_rep = 1'b0;
  end
`else
  assign w_rep = 1'b0;
`endif

  assign o_press = r_pulse | w_rep;

endmodule

// File: rtl/rtc_time_set.sv
// rtc_time_set: button-driven HH/MM/SS editor with commit strobe.
// Optional auto-repeat on inc/dec via RTC_SET_AUTOREPEAT_EN.
module rtc_time_set
  import rtc_pkg::*;
#(
  parameter int unsigned CLKFREQ     = 50000000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned TIMEOUT_S   = 10
`ifdef RTC_SET_AUTOREPEAT_EN
  , parameter int unsigned REPEAT_DELAY_MS = 500
  , parameter int unsigned REPEAT_RATE_MS  = 100
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  rtc_time_set_if.slave bus
);

  localparam int unsigned DEB_CYC = ms2cyc(CLKFREQ, DEBOUNCE_MS);
  localparam int unsigned TO_CYC  = s2cyc(CLKFREQ, TIMEOUT_S);
  localparam int unsigned TW      = $clog2(TO_CYC + 1);
`ifdef RTC_SET_AUTOREPEAT_EN
  localparam int unsigned REP_DLY  = ms2cyc(CLKFREQ, REPEAT_DELAY_MS);
  localparam int unsigned REP_RATE = ms2cyc(CLKFREQ, REPEAT_RATE_MS);
`endif

  rtc_state_t    r_state;
  rtc_state_t    w_next;
  logic [7:0]    r_hh;
  logic [7:0]    r_mm;
  logic [7:0]    r_ss;
  logic          r_wr;
  logic [TW-1:0] r_to_cnt;
  logic          w_mode;
  logic          w_inc;
  logic          w_dec;
  logic          w_step;
  logic          w_in_set;
  logic          w_to;
  logic          w_editing;
  fsel_t         w_fsel;

  button_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_mode (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (bus.btn_mode),
    .o_press(w_mode)
  );

  button_debounce #(
    .DEB_CYC(DEB_CYC)
`ifdef RTC_SET_AUTOREPEAT_EN
    , .REPEAT(1'b1), .REP_DLY(REP_DLY), .REP_RATE(REP_RATE)
`endif
  ) u_inc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (bus.btn_inc),
    .o_press(w_inc)
  );

  button_debounce #(
    .DEB_CYC(DEB_CYC)
`ifdef RTC_SET_AUTOREPEAT_EN
    , .REPEAT(1'b1), .REP_DLY(REP_DLY), .REP_RATE(REP_RATE)
`endif
  ) u_dec (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (bus.btn_dec),
    .o_press(w_dec)
  );

  assign w_in_set = (r_state == SET_HH) || (r_state == SET_MM) ||
                    (r_state == SET_SS);
  // mode beats inc/dec; inc together with dec cancels out
  assign w_step   = !w_mode && (w_inc ^ w_dec);
  assign w_to     = w_in_set && (r_to_cnt == TW'(TO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_mode) w_next = SET_HH;
      SET_HH:  if (w_mode) w_next = SET_MM;
               else if (w_to) w_next = IDLE;
      SET_MM:  if (w_mode) w_next = SET_SS;
               else if (w_to) w_next = IDLE;
      SET_SS:  if (w_mode) w_next = COMMIT;
               else if (w_to) w_next = IDLE;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_editing = 1'b0;
    w_fsel    = FS_NONE;
    unique case (r_state)
      SET_HH:  begin w_editing = 1'b1; w_fsel = FS_HH; end
      SET_MM:  begin w_editing = 1'b1; w_fsel = FS_MM; end
      SET_SS:  begin w_editing = 1'b1; w_fsel = FS_SS; end
      default: begin w_editing = 1'b0; w_fsel = FS_NONE; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr     <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_wr <= (w_next == COMMIT);
      if (!w_in_set || w_mode || w_inc || w_dec)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hh <= '0;
      r_mm <= '0;
      r_ss <= '0;
    end else if (r_state == IDLE && w_mode) begin
      r_hh <= bus.cur_hours;
      r_mm <= bus.cur_minutes;
      r_ss <= bus.cur_seconds;
    end else if (w_step) begin
      unique case (r_state)
        SET_HH:  r_hh <= wrap_step(r_hh, HOURS_MOD, w_inc);
        SET_MM:  r_mm <= wrap_step(r_mm, MINSEC_MOD, w_inc);
        SET_SS:  r_ss <= wrap_step(r_ss, MINSEC_MOD, w_inc);
        default: ;
      endcase
    end
  end

  assign bus.hhmmss    = {8'h00, r_hh, r_mm, r_ss};
  assign bus.wr        = r_wr;
  assign bus.editing   = w_editing;
  assign bus.field_sel = w_fsel;

endmodule

// File: tb/tb_rtc_time_set.sv
// tb_rtc_time_set: random and directed button sequences checked
// against a field-edit reference model.
module tb_rtc_time_set;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rtc_time_set_if bus();

  rtc_time_set #(
    .CLKFREQ    (1000),
    .DEBOUNCE_MS(2),
    .TIMEOUT_S  (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  int          wr_seen = 0;
  logic [31:0] wr_word = '0;

  always @(negedge clk) begin
    if (bus.wr === 1'b1) begin
      wr_seen++;
      wr_word = bus.hhmmss;
    end
  end

  // model: 0 idle, 1 hours, 2 minutes, 3 seconds
  int          m_st = 0;
  int          m_h = 0, m_m = 0, m_s = 0;
  int          m_wr = 0;
  logic [31:0] m_word = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int bump(input int v, input int md, input bit up);
    if (up) return (v < md) ? (v + 1) % md : 0;
    return (v < md) ? (v + md - 1) % md : md - 1;
  endfunction

  function automatic logic [31:0] mword();
    return {8'h00, 8'(m_h), 8'(m_m), 8'(m_s)};
  endfunction

  task automatic model_press(input bit md, input bit up, input bit dn);
    if (md) begin
      case (m_st)
        0: begin
          m_h = int'(bus.cur_hours);
          m_m = int'(bus.cur_minutes);
          m_s = int'(bus.cur_seconds);
          m_st = 1;
        end
        1: m_st = 2;
        2: m_st = 3;
        default: begin
          m_wr++;
          m_word = mword();
          m_st = 0;
        end
      endcase
    end else if (up != dn) begin
      case (m_st)
        1: m_h = bump(m_h, 24, up);
        2: m_m = bump(m_m, 60, up);
        3: m_s = bump(m_s, 60, up);
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".word"}, bus.hhmmss, mword());
    chk({tag, ".edit"}, 32'(bus.editing), 32'(m_st != 0));
    chk({tag, ".fsel"}, 32'(bus.field_sel), 32'(m_st));
    chk({tag, ".wrs"}, 32'(wr_seen), 32'(m_wr));
    if (m_wr > 0) chk({tag, ".wrword"}, wr_word, m_word);
  endtask

  task automatic press(input bit md, input bit up, input bit dn,
                       input string tag);
    bus.btn_mode = md;
    bus.btn_inc  = up;
    bus.btn_dec  = dn;
    tick(6);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_dec  = 1'b0;
    tick(8);
    model_press(md, up, dn);
    check_all(tag);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    bus.cur_hours   = 8'(h);
    bus.cur_minutes = 8'(m);
    bus.cur_seconds = 8'(s);
  endtask

  initial begin
    int n;
    int r;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_dec  = 1'b0;
    set_cur(0, 0, 0);
    tick(2);
    #1;
    chk("rst.word", bus.hhmmss, 32'h0);
    chk("rst.wr", 32'(bus.wr), 32'h0);
    chk("rst.edit", 32'(bus.editing), 32'h0);
    chk("rst.fsel", 32'(bus.field_sel), 32'h0);
    rst_n = 1'b1;
    tick(3);

    set_cur(12, 34, 56);
    press(1, 0, 0, "enter");
    chk("enter.hh", bus.hhmmss, 32'h000C2238);
    @(negedge clk);
    bus.btn_inc = 1'b1;
    @(negedge clk);
    bus.btn_inc = 1'b0;
    tick(10);
    check_all("glitch");
    press(1, 0, 0, "m1");
    press(1, 0, 0, "m2");
    press(1, 0, 0, "m3");
    chk("commit.word", wr_word, 32'h000C2238);
    chk("commit.once", 32'(wr_seen), 32'd1);

    set_cur(23, 0, 0);
    press(1, 0, 0, "w.enter");
    press(0, 1, 0, "w.hinc");
    press(0, 0, 1, "w.hdec");
    press(1, 0, 0, "w.tomm");
    press(0, 0, 1, "w.mdec");
    press(1, 0, 0, "w.toss");
    press(0, 1, 1, "w.both");
    press(1, 1, 0, "w.modeinc");

    set_cur(1, 2, 3);
    press(1, 0, 0, "to.enter");
    press(1, 0, 0, "to.mm");
    tick(900);
    #1;
    chk("to.still", 32'(bus.editing), 32'h1);
    n = 0;
    while (bus.editing !== 1'b0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("to.exit", 32'(bus.editing), 32'h0);
    m_st = 0;
    check_all("to");

    for (int i = 0; i < 80; i++) begin
      if (m_st == 0)
        set_cur($urandom_range(0, 31), $urandom_range(0, 63),
                $urandom_range(0, 63));
      r = $urandom_range(0, 9);
      if (r <= 2)      press(1, 0, 0, "rnd.mode");
      else if (r <= 5) press(0, 1, 0, "rnd.inc");
      else if (r <= 7) press(0, 0, 1, "rnd.dec");
      else if (r == 8) press(0, 1, 1, "rnd.both");
      else             press(1, 1, 1, "rnd.all");
    end

    while (m_st != 0) press(1, 0, 0, "pre.rst");
    set_cur(7, 8, 9);
    press(1, 0, 0, "r.enter");
    press(1, 0, 0, "r.mm");
    press(0, 1, 0, "r.minc");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid.word", bus.hhmmss, 32'h0);
    chk("mid.wr", 32'(bus.wr), 32'h0);
    chk("mid.edit", 32'(bus.editing), 32'h0);
    chk("mid.fsel", 32'(bus.field_sel), 32'h0);
    tick(3);
    rst_n = 1'b1;
    m_st = 0;
    m_h = 0;
    m_m = 0;
    m_s = 0;
    tick(5);
    check_all("post.rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_time_set.md
Name: rtc_time_set

Overview:
- Front-panel time-setting controller sitting directly upstream of the real-time clock.
- Debounces three raw push-buttons and lets the user edit hours, minutes and seconds in sequence.
- On confirmation, issues a one-cycle write strobe together with the packed 32-bit time word the clock loads.
- Edit starts from the clock's current time, which is fed back into this block.

Parameters:
- CLKFREQ, 50000000, clock frequency in Hz.
- DEBOUNCE_MS, 20, time a raw button level must stay stable before it is accepted.
- TIMEOUT_S, 10, edit-mode inactivity timeout in seconds.
- REPEAT_DELAY_MS, 500, hold time before auto-repeat starts (optional feature only).
- REPEAT_RATE_MS, 100, auto-repeat period (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_mode  in  1  raw button, asynchronous, active-high
- btn_inc  in  1  raw button, active-high
- btn_dec  in  1  raw button, active-high
- cur_hours  in  8  clock's current hours, binary 0..23
- cur_minutes  in  8  clock's current minutes, binary 0..59
- cur_seconds  in  8  clock's current seconds, binary 0..59
- hhmmss  out  32  {8'h00, HH, MM, SS}, binary
- wr  out  1  one-cycle load strobe to the clock
- editing  out  1  high in any SET_* state
- field_sel  out  2  0 = none, 1 = HH, 2 = MM, 3 = SS; used by the display to blink the field

Behaviour:
- Reset (asynchronous, rst_n low):
  - state IDLE; wr = 0; editing = 0; field_sel = 0.
  - edit registers hh, mm, ss = 0; hhmmss = 0.
  - debouncers cleared, stable level 0.
- Debounce, per button:
  - 2-flop synchronizer.
  - Counter counts up while the synchronized level differs from the stable level; it clears when they are equal.
  - When the count reaches DEB_CYC = CLKFREQ/1000*DEBOUNCE_MS, the stable level takes the synchronized level.
  - A 0->1 transition of the stable level gives a one-cycle press pulse.
  - Latency from raw edge to pulse: 2 + DEB_CYC + 1 cycles.
- FSM states: IDLE, SET_HH, SET_MM, SET_SS, COMMIT.
  - IDLE: a mode press captures cur_* into hh, mm, ss and moves to SET_HH. inc/dec presses are ignored.
  - SET_HH: inc gives hh = (hh == 23) ? 0 : hh + 1; dec gives hh = (hh == 0) ? 23 : hh - 1. Mode moves to SET_MM.
  - SET_MM: same wrap rules with modulus 60 on mm. Mode moves to SET_SS.
  - SET_SS: same wrap rules with modulus 60 on ss. Mode moves to COMMIT.
  - COMMIT: lasts exactly one cycle with wr = 1, then returns to IDLE.
- Outputs:
  - hhmmss is continuously driven as {8'h00, hh, mm, ss}.
  - wr is registered and high only in COMMIT.
  - Edit values are never written back from cur_* except on entry to SET_HH.
- Priority and simultaneous events:
  - mode press in the same cycle as inc/dec: mode wins and inc/dec is dropped.
  - inc and dec in the same cycle: both dropped.
- Timeout:
  - Inactivity counter runs in SET_* states and clears on any accepted press.
  - At TIMEOUT_S*CLKFREQ cycles, the FSM returns to IDLE with no wr; hh/mm/ss keep their values.
- Reset asserted mid-edit: immediate return to IDLE, no wr emitted.
- Out-of-range cur_* values (e.g. hours = 30) captured on entry: the first inc or dec reduces the field to 0 (inc) or modulus-1 (dec).

Optional Feature:
- Macro: RTC_SET_AUTOREPEAT_EN.
- Defined: an inc/dec button whose stable level stays high for REPEAT_DELAY_MS generates further press pulses every REPEAT_RATE_MS until release. Repeat pulses are treated exactly as presses, including timeout clearing.
- Undefined: one pulse per press; the repeat counters are not synthesized.

Decomposition:
- Package rtc_pkg holds:
  - state enum {IDLE, SET_HH, SET_MM, SET_SS, COMMIT};
  - field_sel encodings;
  - constants HOURS_MOD = 24 and MINSEC_MOD = 60;
  - derived cycle-count helper functions (ms to cycles).
- Sub-module button_debounce (synchronizer, debounce counter, press pulse, optional repeat), instantiated three times.
- Controller FSM and edit registers stay in rtc_time_set.

Test Plan (CLKFREQ = 1000, DEBOUNCE_MS = 2, so DEB_CYC = 2; TIMEOUT_S = 1):
- Raw btn_inc glitch high for 1 cycle in SET_HH -> no press pulse, hh unchanged.
- cur = 12:34:56; mode press -> SET_HH with hh = 12; mode, mode, mode -> COMMIT. wr high for exactly 1 cycle with hhmmss = 32'h000C2238, then IDLE.
- In SET_HH with hh = 23, inc -> 0; dec -> 23. In SET_MM with mm = 0, dec -> 59.
- In SET_SS, inc and dec presses aligned to the same cycle -> ss unchanged. mode and inc aligned -> state SET_SS -> COMMIT and ss unchanged.
- Enter SET_MM and stay idle 1000 cycles -> IDLE, editing = 0, wr never asserted.
- rst_n pulsed low mid-SET_MM -> outputs immediately at reset values, no wr. With RTC_SET_AUTOREPEAT_EN, REPEAT_DELAY_MS = 5 and REPEAT_RATE_MS = 2, holding inc for 12 ms after acceptance in SET_SS from ss = 0 -> ss = 4.
